// File: rtl/cic_interp.sv
// cic_interp: CIC interpolator for the transmit path.
//
// Low-rate samples arrive through a valid/ready handshake into a single-entry
// hold register. On every phase-0 high-rate strobe the hold register (or zero
// if empty) is pushed through STAGES comb stages. STAGES integrators then run
// once per out_strobe on the zero-stuffed comb output. The output slice removes
// the DC gain RATE**(STAGES-1).
//
// Optional build macro: CIC_INTERP_ROUND_EN
//   defined   -> round half up before dropping the LSBs
//   undefined -> plain truncation
//
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   out_strobe  high-rate tick from downstream, one output per tick
//   in_data     signed low-rate sample
//   in_valid    in_data valid
//   in_ready    sample can be accepted this cycle
//   out_data    signed interpolated sample
//   out_valid   one-clock pulse, one clock after each strobe while running
//   underrun    sticky flag: the hold register was empty when a sample was needed
module cic_interp #(
  parameter int IN_WIDTH  = 16,
  parameter int STAGES    = 3,
  parameter int LOG2_RATE = 2,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 out_strobe,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 underrun
);

  localparam int ACC  = IN_WIDTH + STAGES * LOG2_RATE;
  localparam int TOP  = IN_WIDTH + (STAGES - 1) * LOG2_RATE;
  localparam int DROP = TOP - OUT_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg, state_next;
  logic [LOG2_RATE-1:0] phase_reg;
  logic [IN_WIDTH-1:0]  hold_reg;
  logic                 full_reg;

  logic run_strobe;
  logic s0;
  logic consume;
  logic accept;

  // c_in[k] feeds comb stage k+1; i_in[k] feeds integrator stage k+1.
  logic [ACC-1:0] c_in [0:STAGES];
  logic [ACC-1:0] i_in [0:STAGES];
  logic [OUT_WIDTH-1:0] out_next;

  always_comb begin
    state_next = state_reg;
    run_strobe = 1'b0;
    s0         = 1'b0;
    consume    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && !full_reg) state_next = RUN;
      end
      RUN: begin
        run_strobe = out_strobe;
        s0         = out_strobe && (phase_reg == '0);
        consume    = s0 && full_reg;
      end
      default: state_next = IDLE;
    endcase
    in_ready = !full_reg || consume;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      hold_reg  <= '0;
      full_reg  <= 1'b0;
      underrun  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_valid <= run_strobe;
      if (run_strobe) begin
        phase_reg <= phase_reg + 1'b1;
        out_data  <= out_next;
      end
      if (s0 && !full_reg) underrun <= 1'b1;
      // Accept wins over consume so a same-cycle swap leaves the register full.
      if (accept) begin
        hold_reg <= in_data;
        full_reg <= 1'b1;
      end else if (consume) begin
        full_reg <= 1'b0;
      end
    end
  end

  assign c_in[0] = full_reg ? {{(ACC-IN_WIDTH){hold_reg[IN_WIDTH-1]}}, hold_reg} : '0;
  // Zero stuffing: the comb output enters the integrators only on phase 0.
  assign i_in[0] = (phase_reg == '0) ? c_in[STAGES] : '0;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      logic [ACC-1:0] comb_reg;
      logic [ACC-1:0] dly_reg;
      logic [ACC-1:0] int_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          comb_reg <= '0;
          dly_reg  <= '0;
          int_reg  <= '0;
        end else begin
          if (s0) begin
            comb_reg <= c_in[gi-1] - dly_reg;
            dly_reg  <= c_in[gi-1];
          end
          if (run_strobe) int_reg <= int_reg + i_in[gi-1];
        end
      end

      assign c_in[gi] = comb_reg;
      assign i_in[gi] = int_reg;
    end
  endgenerate

`ifdef CIC_INTERP_ROUND_EN
  generate
    if (DROP > 0) begin : g_round
      // Adding half an LSB then truncating equals adding the top dropped bit
      // to the truncated value, which avoids a full-width adder.
      assign out_next = i_in[STAGES][TOP-1 -: OUT_WIDTH]
                      + {{(OUT_WIDTH-1){1'b0}}, i_in[STAGES][DROP-1]};
    end else begin : g_exact
      assign out_next = i_in[STAGES][TOP-1 -: OUT_WIDTH];
    end
  endgenerate
`else
  assign out_next = i_in[STAGES][TOP-1 -: OUT_WIDTH];
`endif

endmodule

// File: tb/tb_cic_interp.sv
module tb_cic_interp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        out_strobe;
  logic        in_valid;
  logic [15:0] in_data;
  logic        rdy_a, ov_a, ur_a;
  logic        rdy_b, ov_b, ur_b;
  logic signed [15:0] od_a;
  logic signed [19:0] od_b;

  // Default widths: gain removed and 4 LSBs dropped.
  cic_interp dut_a (
    .clock(clock), .reset_n(reset_n), .out_strobe(out_strobe),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .out_data(od_a), .out_valid(ov_a), .underrun(ur_a)
  );

  // Full-precision output: raw integrator value, nothing dropped.
  cic_interp #(.OUT_WIDTH(20)) dut_b (
    .clock(clock), .reset_n(reset_n), .out_strobe(out_strobe),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
    .out_data(od_b), .out_valid(ov_b), .underrun(ur_b)
  );

  int total = 0;
  int bad   = 0;
  int out_a[$];
  int out_b[$];
  int mode, dc_val, n_smp;
  bit src_on;
  bit last_fire;
  int tbl [8]  = '{5, -3, 100, -200, 7, 0, -50, 33};
  int h   [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int smp(input int n);
    case (mode)
      0:       return (n == 0) ? 1 : 0;
      1:       return dc_val;
      2:       return n;
      default: return tbl[n % 8];
    endcase
  endfunction

  // Expected full-precision output at strobe k: convolution of the
  // zero-stuffed input with the RATE=4, N=3 CIC kernel, 15 strobes late.
  function automatic int model_b(input int k);
    int acc = 0;
    int m;
    for (int j = 0; j < 10; j++) begin
      m = k - 15 - j;
      if (m >= 0 && (m % 4) == 0) acc += h[j] * smp(m / 4);
    end
    return acc;
  endfunction

  function automatic int model_a(input int k);
    int v = model_b(k);
`ifdef CIC_INTERP_ROUND_EN
    return (v + 8) >>> 4;
`else
    return v >>> 4;
`endif
  endfunction

  function automatic int qa(input int k);
    return (k >= 0 && k < out_a.size()) ? out_a[k] : -999999;
  endfunction

  function automatic int qb(input int k);
    return (k >= 0 && k < out_b.size()) ? out_b[k] : -999999;
  endfunction

  task automatic tick(input bit stb);
    int v;
    bit fire;
    out_strobe = stb;
    in_valid   = src_on;
    v          = smp(n_smp);
    in_data    = v[15:0];
    @(negedge clock);
    fire = in_valid && rdy_a;
    @(posedge clock);
    #1;
    out_strobe = 1'b0;
    last_fire  = fire;
    if (fire) n_smp++;
    if (ov_a) out_a.push_back(int'(od_a));
    if (ov_b) out_b.push_back(int'(od_b));
  endtask

  task automatic run(input int nstb, input int gap);
    for (int i = 0; i < nstb; i++) begin
      tick(1'b1);
      for (int g = 1; g < gap; g++) tick(1'b0);
    end
  endtask

  task automatic restart(input int m, input int dcv);
    reset_n    = 1'b0;
    out_strobe = 1'b0;
    src_on     = 1'b0;
    in_valid   = 1'b0;
    mode       = m;
    dc_val     = dcv;
    n_smp      = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_a.delete();
    out_b.delete();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cnt, badph, viol;
    int dcs [3] = '{1000, -1000, 32767};
    int gaps[2] = '{1, 7};

    reset_n    = 1'b0;
    out_strobe = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    src_on     = 1'b0;
    mode       = 0;
    dc_val     = 0;
    n_smp      = 0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_out_data", int'(od_a), 0);
    check_val("rst_out_valid", int'(ov_a), 0);
    check_val("rst_in_ready", int'(rdy_a), 1);
    check_val("rst_underrun", int'(ur_a), 0);

    // Impulse, strobe every 3 clocks.
    restart(0, 0);
    src_on = 1'b1;
    tick(1'b0);
    run(30, 3);
    check_val("imp_count", out_b.size(), 30);
    for (int k = 0; k < 30; k++) begin
      check_val($sformatf("imp_full[%0d]", k), qb(k), model_b(k));
      check_val($sformatf("imp_slice[%0d]", k), qa(k), model_a(k));
    end
    check_val("imp_underrun", int'(ur_a), 0);

    // DC gain.
    for (int d = 0; d < 3; d++) begin
      restart(1, dcs[d]);
      src_on = 1'b1;
      tick(1'b0);
      run(40, 1);
      for (int k = 36; k < 40; k++)
        check_val($sformatf("dc%0d_out[%0d]", dcs[d], k), qa(k), dcs[d]);
      check_val($sformatf("dc%0d_full", dcs[d]), qb(39), 16 * dcs[d]);
    end

    // Handshake with a ramp and back-to-back strobes.
    restart(2, 0);
    src_on = 1'b1;
    tick(1'b0);
    cnt   = 0;
    badph = 0;
    for (int i = 0; i < 48; i++) begin
      tick(1'b1);
      if (i >= 4 && last_fire) begin
        cnt++;
        if ((i % 4) != 0) badph++;
      end
    end
    check_val("hs_accepts", cnt, 11);
    check_val("hs_off_phase", badph, 0);
    viol = 0;
    for (int k = 0; k < 47; k++) if (qa(k + 1) < qa(k)) viol++;
    check_val("ramp_monotonic", viol, 0);
    for (int k = 30; k < 47; k++)
      check_val($sformatf("ramp_step[%0d]", k), qb(k + 1) - qb(k), 4);
    check_val("ramp_model", qb(40), model_b(40));
    check_val("ramp_underrun", int'(ur_a), 0);

    // Underrun, then reset mid-stream.
    restart(1, 1000);
    src_on = 1'b1;
    tick(1'b0);
    run(8, 1);
    check_val("ur_before", int'(ur_a), 0);
    src_on = 1'b0;
    run(8, 1);
    check_val("ur_set", int'(ur_a), 1);
    src_on = 1'b1;
    run(32, 1);
    check_val("ur_sticky", int'(ur_a), 1);
    check_val("ur_full_count", out_a.size(), 48);
    check_val("ur_resettle", qa(47), 1000);
    src_on = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_out_data", int'(od_a), 0);
    check_val("mid_rst_out_full", int'(od_b), 0);
    check_val("mid_rst_out_valid", int'(ov_a), 0);
    check_val("mid_rst_in_ready", int'(rdy_a), 1);
    check_val("mid_rst_underrun", int'(ur_a), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_a.delete();
    out_b.delete();
    run(10, 1);
    check_val("idle_no_valid", out_a.size(), 0);
    src_on = 1'b1;
    tick(1'b0);
    run(5, 1);
    check_val("run_after_accept", out_a.size(), 5);

    // Same sequence with dense and sparse strobes.
    for (int g = 0; g < 2; g++) begin
      restart(3, 0);
      src_on = 1'b1;
      tick(1'b0);
      run(40, gaps[g]);
      for (int k = 12; k < 40; k++)
        check_val($sformatf("gap%0d_full[%0d]", gaps[g], k), qb(k), model_b(k));
      for (int k = 30; k < 40; k++)
        check_val($sformatf("gap%0d_slice[%0d]", gaps[g], k), qa(k), model_a(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- CIC interpolator: transmit-side counterpart of the decimating comb/integrator chain.
- Accepts low-rate samples through a valid/ready handshake and runs them through STAGES registered comb stages at the low rate.
- Zero-stuffs by RATE, then runs STAGES integrators at the high rate paced by out_strobe.
- Sits between the TX baseband source and the DUC/NCO mixer.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- STAGES, 3, number of comb stages and number of integrator stages (N).
- LOG2_RATE, 2, interpolation ratio RATE = 2**LOG2_RATE (power of two only).
- OUT_WIDTH, 16, output width; must be <= IN_WIDTH+(STAGES-1)*LOG2_RATE.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- out_strobe  in  1  high-rate sample tick from downstream; one output per strobe
- in_data  in  IN_WIDTH  signed low-rate sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- out_data  out  OUT_WIDTH  signed interpolated sample
- out_valid  out  1  one-clock pulse, one clock after each strobe in RUN
- underrun  out  1  sticky: low-rate sample missing when needed

Behaviour:
- Internal width ACC = IN_WIDTH + STAGES*LOG2_RATE. All comb and integrator arithmetic is two's complement modulo 2**ACC; wrap is legal.
- Reset (async, any time, including mid-stream) clears:
  - every comb delay, comb output, integrator and the phase counter;
  - the hold register (empty) and underrun;
  - out_data=0 and out_valid=0; state=IDLE.
- Hold register: single entry.
  - in_ready = !full | consume_this_cycle.
  - Transfer occurs when in_valid & in_ready.
  - Simultaneous consume and accept leaves the register full with the new sample.
- FSM:
  - IDLE: phase held at 0; combs and integrators frozen; strobes ignored; out_valid stays 0. First accepted sample -> RUN.
  - RUN: every out_strobe advances phase modulo RATE. No return to IDLE except via reset.
- Phase-0 strobe ("S0"), comb update:
  - c0 = hold register if full, else 0. If empty, set underrun (sticky).
  - For k=1..STAGES, all registered and updated simultaneously: comb_k <= c_{k-1} - d_k; d_k <= c_{k-1}.
  - Each c_{k-1} is the pre-edge value, sign-extended to ACC.
- Every strobe in RUN, integrator update:
  - Integrator 1 input is comb_STAGES when phase==0, else 0.
  - int_k <= int_k + int_{k-1}, all registered.
  - out_data <= int_STAGES[IN_WIDTH+(STAGES-1)*LOG2_RATE-1 -: OUT_WIDTH], i.e. DC gain RATE**(STAGES-1) removed, then truncated.
- Latency: a sample consumed at strobe index 0 first affects out_data on strobe index STAGES*(RATE+1), which is 15 for defaults with RATE=4.
- out_strobe on consecutive clocks is legal.

Optional Feature:
- Macro: CIC_INTERP_ROUND_EN.
- Defined: add 2**(dropped_lsbs-1) to int_STAGES before the slice (round half up), where dropped_lsbs = IN_WIDTH+(STAGES-1)*LOG2_RATE-OUT_WIDTH. If dropped_lsbs==0 there is no adder.
- Undefined: plain truncation, as above.

Test Plan:
- Impulse, no truncation: OUT_WIDTH=20, STAGES=3, RATE=4, in=1 then zeros fed continuously, strobe every 3 clocks -> out_data from strobe 15 = 1,3,6,10,12,12,10,6,3,1, then 0; underrun=0.
- DC gain, defaults (OUT_WIDTH=16): constant +1000 -> settles at 1000 every strobe. Constant -1000 -> -1000. Constant 32767 -> 32767, no wrap.
- Rounding, default widths, impulse in=1:
  - macro off: all outputs 0;
  - macro on: 0,0,0,1,1,1,1,0,0,0.
- Handshake: hold in_valid=1 with strobes every clock -> in_ready high exactly once per 4 strobes after the first fill. No sample lost or duplicated (ramp 0,1,2,... in gives a monotonic ramp out). in_valid withheld for one low-rate period -> underrun=1 and stays 1.
- Reset mid-stream: assert reset_n=0 during DC 1000 output -> out_data=0, out_valid=0, in_ready=1, underrun=0 immediately. After release, strobes produce no out_valid until the first sample is accepted.
- Back-to-back strobes versus sparse strobes (every 7 clocks) with the same input sequence -> identical out_data sequence.
